// File: rtl/esp_bus_master.sv
// esp_bus_master: bus initiator turning ESP SPI messages into word read/write and block-fill accesses.
// Optional access timeout is enabled by defining ESP_BUS_MASTER_TIMEOUT_EN.
module esp_bus_master #(
    parameter logic [7:0] CMD_WR32    = 8'h40,
    parameter logic [7:0] CMD_RD32    = 8'h41,
    parameter logic [7:0] CMD_SETDATA = 8'h42,
    parameter logic [7:0] CMD_FILL    = 8'h43,
    parameter logic [7:0] CMD_STATUS  = 8'h44
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
   ,parameter int         TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_msg_end,
    input  logic [7:0]  spi_cmd,
    input  logic [63:0] spi_rxdata,
    output logic [63:0] spi_txdata,
    output logic        spi_txdata_valid,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wrdata,
    output logic [3:0]  bus_bytesel,
    output logic        bus_wren,
    output logic        bus_strobe,
    input  logic        bus_wait,
    input  logic [31:0] bus_rddata,
    input  logic        bus_error,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, ACCESS, NEXT} state_t;
    state_t      state;
    logic [31:0] data_reg;
    logic [15:0] count;
    logic        is_fill, err_f, ovr_f, timeout_f, done, start;
    assign done = bus_strobe && !bus_wait;
    assign start = spi_msg_end && (spi_cmd == CMD_WR32 || spi_cmd == CMD_RD32 ||
                   (spi_cmd == CMD_FILL && spi_rxdata[47:32] != 16'd0));
    assign bus_bytesel = 4'hF;
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
    logic [31:0] tcnt;
`else
    assign timeout_f = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus_req          <= 1'b0;
            bus_strobe       <= 1'b0;
            bus_wren         <= 1'b0;
            bus_addr         <= '0;
            bus_wrdata       <= '0;
            spi_txdata       <= '0;
            spi_txdata_valid <= 1'b0;
            busy             <= 1'b0;
            data_reg         <= '0;
            count            <= '0;
            is_fill          <= 1'b0;
            err_f            <= 1'b0;
            ovr_f            <= 1'b0;
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
            timeout_f        <= 1'b0;
            tcnt             <= '0;
`endif
        end else begin
            // STATUS is serviced in any state; flags set later in this cycle survive the clear
            if (spi_msg_end && spi_cmd == CMD_STATUS) begin
                spi_txdata       <= {60'd0, timeout_f, err_f, ovr_f, busy};
                spi_txdata_valid <= 1'b1;
                err_f            <= 1'b0;
                ovr_f            <= 1'b0;
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
                timeout_f        <= 1'b0;
`endif
            end else if (spi_msg_end && state != IDLE) begin
                ovr_f <= 1'b1;
            end
            case (state)
                IDLE: if (spi_msg_end) begin
                    if (spi_cmd inside {CMD_WR32, CMD_RD32, CMD_SETDATA, CMD_FILL})
                        spi_txdata_valid <= 1'b0;
                    if (spi_cmd == CMD_SETDATA)
                        data_reg <= spi_rxdata[31:0];
                    if (start) begin
                        state      <= REQ;
                        bus_req    <= 1'b1;
                        busy       <= 1'b1;
                        bus_addr   <= {spi_rxdata[31:2], 2'b00};
                        bus_wren   <= spi_cmd != CMD_RD32;
                        bus_wrdata <= spi_cmd == CMD_FILL ? data_reg : spi_rxdata[63:32];
                        is_fill    <= spi_cmd == CMD_FILL;
                        count      <= spi_rxdata[47:32];
                    end
                end
                REQ: if (bus_gnt) begin
                    state      <= ACCESS;
                    bus_strobe <= 1'b1;
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
                    tcnt       <= '0;
`endif
                end
                ACCESS: if (done) begin
                    bus_strobe <= 1'b0;
                    if (bus_error)
                        err_f <= 1'b1;
                    if (!bus_wren) begin
                        spi_txdata       <= bus_error ? '1 : {32'd0, bus_rddata};
                        spi_txdata_valid <= 1'b1;
                    end
                    if (is_fill && !bus_error) begin
                        state <= NEXT;
                    end else begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
                else if (bus_strobe && bus_wait && tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    bus_strobe <= 1'b0;
                    timeout_f  <= 1'b1;
                    if (!bus_wren) begin
                        spi_txdata       <= '1;
                        spi_txdata_valid <= 1'b1;
                    end
                    state   <= IDLE;
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                end
`endif
                else begin
                    // a lost grant parks the strobe until it returns, then the access is re-issued
                    bus_strobe <= bus_gnt;
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
                    if (bus_strobe && bus_wait)
                        tcnt <= tcnt + 32'd1;
`endif
                end
                default: begin
                    count    <= count - 16'd1;
                    bus_addr <= bus_addr + 32'd4;
                    if (count == 16'd1) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        state      <= ACCESS;
                        bus_strobe <= bus_gnt;
`ifdef ESP_BUS_MASTER_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_esp_bus_master.sv
// tb_esp_bus_master: directed scoreboard bench for esp_bus_master with a simple memory responder.
// Timeout checks run only when ESP_BUS_MASTER_TIMEOUT_EN is defined.
module tb_esp_bus_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_msg_end = 1'b0;
    logic [7:0]  spi_cmd = '0;
    logic [63:0] spi_rxdata = '0;
    logic [63:0] spi_txdata;
    logic        spi_txdata_valid;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [31:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic [3:0]  bus_bytesel;
    logic        bus_wren;
    logic        bus_strobe;
    logic        bus_wait;
    logic [31:0] bus_rddata;
    logic        bus_error;
    logic        busy;

    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bsel;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        obs_q[$];
    logic [31:0] mem [64];
    int          wait_cfg = 0;
    logic        stuck = 1'b0;
    int          err_at = -1;
    int          ncomp = 0;
    int          nstrobe = 0;
    int          wcnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

`ifdef ESP_BUS_MASTER_TIMEOUT_EN
    esp_bus_master #(.TIMEOUT_CYCLES(16)) dut (
`else
    esp_bus_master dut (
`endif
        .clk(clk), .reset_n(reset_n), .spi_msg_end(spi_msg_end), .spi_cmd(spi_cmd),
        .spi_rxdata(spi_rxdata), .spi_txdata(spi_txdata), .spi_txdata_valid(spi_txdata_valid),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
        .bus_bytesel(bus_bytesel), .bus_wren(bus_wren), .bus_strobe(bus_strobe),
        .bus_wait(bus_wait), .bus_rddata(bus_rddata), .bus_error(bus_error), .busy(busy)
    );

    assign bus_wait   = stuck || (bus_strobe && wcnt < wait_cfg);
    assign bus_rddata = mem[bus_addr[7:2]];
    assign bus_error  = ncomp == err_at;

    always @(posedge clk) begin
        if (bus_strobe)
            nstrobe <= nstrobe + 1;
        wcnt <= (bus_strobe && bus_wait) ? wcnt + 1 : 0;
        if (bus_strobe && !bus_wait) begin
            obs_q.push_back({bus_wren, bus_addr, bus_wren ? bus_wrdata : bus_rddata, bus_bytesel});
            if (bus_wren)
                mem[bus_addr[7:2]] <= bus_wrdata;
            ncomp <= ncomp + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] cmd, input logic [63:0] d);
        @(negedge clk);
        spi_cmd = cmd;
        spi_rxdata = d;
        spi_msg_end = 1'b1;
        @(negedge clk);
        spi_msg_end = 1'b0;
    endtask

    task automatic expect_acc(input logic wren, input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({wren, addr, data, 4'hF});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 2000, 1);
    endtask

    task automatic drain(input string tag);
        acc_t o, e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            chk(tag, o, e);
        end
        chk({tag, " extra"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst req", bus_req, 0);
        chk("rst strobe", bus_strobe, 0);
        chk("rst wren", bus_wren, 0);
        chk("rst valid", spi_txdata_valid, 0);
        chk("rst addr", bus_addr, 0);
        chk("rst wrdata", bus_wrdata, 0);
        chk("rst txdata", spi_txdata, 0);
        chk("rst bytesel", bus_bytesel, 4'hF);
        reset_n = 1'b1;

        send(8'h42, 64'hDEADBEEF);
        chk("setdata busy", busy, 0);
        for (int i = 0; i < 3; i++) expect_acc(1'b1, 32'hFFF00010 + 32'(4 * i), 32'hDEADBEEF);
        send(8'h43, {16'd0, 16'd3, 32'hFFF00010});
        wait_idle("fill3 idle");
        drain("fill3");

        expect_acc(1'b1, 32'hFFF00100, 32'h12345678);
        send(8'h40, {32'h12345678, 32'hFFF00100});
        wait_idle("wr32 idle");
        wait_cfg = 2;
        expect_acc(1'b0, 32'hFFF00100, 32'h12345678);
        send(8'h41, {32'd0, 32'hFFF00102});
        wait_idle("rd32 idle");
        chk("rd32 data", spi_txdata, 64'h00000000_12345678);
        chk("rd32 valid", spi_txdata_valid, 1);
        drain("wr_rd");

        wait_cfg = 0;
        expect_acc(1'b0, 32'hFFF00100, 32'h12345678);
        send(8'h41, {32'd0, 32'hFFF00100});
        chk("lat cycle1 valid", spi_txdata_valid, 0);
        @(negedge clk);
        chk("lat cycle2 valid", spi_txdata_valid, 0);
        @(negedge clk);
        chk("lat cycle3 valid", spi_txdata_valid, 1);
        wait_idle("lat idle");
        drain("lat");

        for (int i = 0; i < 100; i++) expect_acc(1'b1, 32'hFFF00000 + 32'(4 * i), 32'hDEADBEEF);
        send(8'h43, {16'd0, 16'd100, 32'hFFF00000});
        send(8'h41, {32'd0, 32'hFFF00100});
        send(8'h44, 64'd0);
        chk("status busy", spi_txdata, 64'h3);
        chk("status valid", spi_txdata_valid, 1);
        wait_idle("fill100 idle");
        drain("fill100");
        send(8'h44, 64'd0);
        chk("status clear", spi_txdata, 64'h0);

        send(8'h42, 64'hA5A5A5A5);
        err_at = ncomp + 1;
        expect_acc(1'b1, 32'hFFF00040, 32'hA5A5A5A5);
        expect_acc(1'b1, 32'hFFF00044, 32'hA5A5A5A5);
        send(8'h43, {16'd0, 16'd4, 32'hFFF00040});
        wait_idle("fillerr idle");
        err_at = -1;
        drain("fillerr");
        send(8'h44, 64'd0);
        chk("status err", spi_txdata, 64'h4);

        send(8'h43, {16'd0, 16'd0, 32'hFFF00020});
        chk("fill0 busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("fill0 busy later", busy, 0);
        chk("fill0 strobe", obs_q.size(), 0);
        expect_acc(1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5);
        expect_acc(1'b1, 32'h00000000, 32'hA5A5A5A5);
        send(8'h43, {16'd0, 16'd2, 32'hFFFFFFFC});
        wait_idle("wrap idle");
        drain("wrap");

        stuck = 1'b1;
        expect_acc(1'b1, 32'hFFF00080, 32'hCAFEF00D);
        send(8'h40, {32'hCAFEF00D, 32'hFFF00080});
        @(negedge clk);
        chk("gnt strobe up", bus_strobe, 1);
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("gnt drop strobe", bus_strobe, 0);
        stuck = 1'b0;
        @(negedge clk);
        chk("gnt drop hold", bus_strobe, 0);
        chk("gnt drop req", bus_req, 1);
        bus_gnt = 1'b1;
        wait_idle("gnt idle");
        drain("gnt");

`ifdef ESP_BUS_MASTER_TIMEOUT_EN
        stuck = 1'b1;
        s0 = nstrobe;
        send(8'h41, {32'd0, 32'hFFF00100});
        wait_idle("tmo idle");
        chk("tmo strobe cycles", nstrobe - s0, 16);
        chk("tmo data", spi_txdata, 64'hFFFFFFFF_FFFFFFFF);
        chk("tmo valid", spi_txdata_valid, 1);
        stuck = 1'b0;
        send(8'h44, 64'd0);
        chk("tmo status", spi_txdata, 64'h8);
`else
        s0 = 0;
`endif

        stuck = 1'b1;
        send(8'h41, {32'd0, 32'hFFF00100});
        repeat (2) @(negedge clk);
        chk("mid strobe up", bus_strobe, 1 + s0 * 0);
        reset_n = 1'b0;
        #1;
        chk("mid rst strobe", bus_strobe, 0);
        chk("mid rst req", bus_req, 0);
        chk("mid rst busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        drain("mid rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/esp_bus_master.md
Name: esp_bus_master

Overview:
- Bus initiator driving the CPU-style system bus (addr/wrdata/bytesel/wren/strobe/wait/rddata/error) from ESP32 core-specific SPI messages.
- Lets the ESP load and inspect SRAM and other bus responders: word read, word write and block fill.
- Sits between aqp_esp_spi (spi_cmd/spi_rxdata/spi_msg_end/spi_txdata) and the bus arbiter, alongside the CPU.

Parameters:
- CMD_WR32, 8'h40, opcode: write one word.
- CMD_RD32, 8'h41, opcode: read one word.
- CMD_SETDATA, 8'h42, opcode: load fill data register.
- CMD_FILL, 8'h43, opcode: write fill data register to N consecutive words.
- CMD_STATUS, 8'h44, opcode: report status.
- TIMEOUT_CYCLES, 1024, wait-cycle limit per access (only with optional feature).

Ports:
- clk  in  1  system clock (28.63636MHz)
- reset_n  in  1  asynchronous active-low reset
- spi_msg_end  in  1  single-cycle pulse; spi_cmd/spi_rxdata valid this cycle
- spi_cmd  in  8  message opcode
- spi_rxdata  in  64  message payload
- spi_txdata  out  64  response data
- spi_txdata_valid  out  1  response available
- bus_req  out  1  request bus from arbiter
- bus_gnt  in  1  arbiter grant
- bus_addr  out  32  byte address, [1:0] always 0
- bus_wrdata  out  32  write data
- bus_bytesel  out  4  byte enables, always 4'hF
- bus_wren  out  1  write access
- bus_strobe  out  1  access request
- bus_wait  in  1  responder stall
- bus_rddata  in  32  read data, valid on completion cycle
- bus_error  in  1  responder error, valid on completion cycle
- busy  out  1  command in progress

Behaviour:
- Reset (reset_n low, async): state IDLE; bus_req, bus_strobe, bus_wren, spi_txdata_valid, busy = 0; bus_addr, bus_wrdata, spi_txdata, data_reg, count = 0; bytesel = 4'hF; status flags cleared.
- Bus handshake: an access completes on a rising edge where bus_strobe=1 and bus_wait=0. The address, wrdata and wren outputs are registered and held stable while strobe=1. strobe is only asserted while bus_gnt=1.
- States:
  - IDLE: waits for spi_msg_end, then decodes spi_cmd.
  - REQ: bus_req=1 until bus_gnt=1.
  - ACCESS: strobe=1 until completion.
  - NEXT: fill bookkeeping.
- Command decode, all addresses taken from spi_rxdata[31:0] with [1:0] forced to 0:
  - WR32: wrdata=rxdata[63:32], wren=1 -> REQ.
  - RD32: wren=0 -> REQ.
  - SETDATA: data_reg=rxdata[31:0]; stays IDLE, no bus activity.
  - FILL: count=rxdata[47:32]. count=0 is a no-op that stays IDLE. Otherwise wrdata=data_reg, wren=1 -> REQ.
  - STATUS: spi_txdata={48'b0, 8'b0, 4'b0, timeout_f, err_f, ovr_f, busy}; spi_txdata_valid=1 the next cycle. Reading status clears err_f, ovr_f and timeout_f.
  - Unknown opcode: ignored.
- busy=1 in every state except IDLE; it asserts the cycle after spi_msg_end is accepted.
- REQ -> ACCESS when bus_gnt=1. Strobe asserts the first cycle after gnt is seen. bus_req stays 1 through ACCESS and NEXT.
- ACCESS completion:
  - Read: spi_txdata={32'b0, bus_rddata}; spi_txdata_valid=1; -> IDLE.
  - Write: -> IDLE, or -> NEXT for FILL.
- NEXT: count decrements and bus_addr increments by 4, wrapping 32'hFFFFFFFC -> 0. If the new count is 0 -> IDLE. Otherwise strobe is reasserted next cycle with bus_req kept high; the grant is not re-arbitrated.
- Minimum latency: RD32 with gnt already high and wait=0 gives spi_txdata_valid 3 cycles after the spi_msg_end edge.
- Errors:
  - bus_error=1 on a completion cycle sets err_f, terminates the command (the remaining fill is aborted) and returns to IDLE.
  - A read with error returns spi_txdata=64'hFFFFFFFF_FFFFFFFF.
- spi_txdata_valid is cleared on acceptance of any new command.
- spi_msg_end while busy: the message is dropped and ovr_f is set. The exception is STATUS, which is always serviced, even mid-transfer, without disturbing the bus.
- bus_gnt dropping during ACCESS is a protocol violation by the arbiter. The master holds strobe low until gnt returns, then re-issues the same access.

Optional Feature:
- Macro ESP_BUS_MASTER_TIMEOUT_EN.
- Defined: a counter runs while in ACCESS with bus_wait=1. When it reaches TIMEOUT_CYCLES:
  - strobe drops and timeout_f is set;
  - the command is aborted and the state returns to IDLE;
  - a read returns all-ones with valid=1.
  - The counter resets at each new access.
- Undefined: no counter, timeout_f reads 0, and an access waits indefinitely.

Test Plan:
- SETDATA 32'hDEADBEEF, FILL addr 32'hFFF00010 count 3, wait=0 -> three writes to ...10/...14/...18 with data DEADBEEF, bytesel F; then IDLE.
- WR32 addr 32'hFFF00100 data 32'h12345678, then RD32 same address, with the responder returning it after 2 wait cycles -> spi_txdata=64'h00000000_12345678, valid=1.
- RD32 sent while a FILL of count 100 is in progress -> dropped; STATUS returns 64'h3 (busy, ovr_f); a second STATUS after completion returns 64'h0.
- bus_error=1 on the 2nd word of a count-4 FILL -> only 2 strobes complete; STATUS returns 64'h4.
- FILL count 0 -> no strobe, busy stays 0. FILL addr 32'hFFFFFFFC count 2 -> addresses FFFFFFFC then 00000000.
- With ESP_BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, RD32 with wait stuck high -> strobe drops after 16 cycles; spi_txdata all-ones; STATUS bit3 set. Also: reset_n pulsed low mid-ACCESS -> strobe and bus_req fall immediately.
